// File: rtl/if_instr_queue.sv
// In-order fetch tracking queue between PC generation / I-cache request and ID.
// Entries are allocated at fetch, filled by in-order I-cache responses, and drained in program order.
module if_instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_Flush,
  input  logic        Req_Valid,
  input  logic [31:0] Req_PC,
  input  logic        Req_AdEL,
  input  logic        Resp_Valid,
  input  logic [31:0] Resp_Instr,
  input  logic        ID_Ready,
  output logic        Q_Full,
  output logic        IF_Valid,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Instr,
  output logic        IF_AdEL
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  // Handshakes: a fetch is allocated when Req_Valid is high and Q_Full is low;
  // the head is consumed when IF_Valid and ID_Ready are both high. IF_Flush
  // overrides allocate, fill, drop and pop in the same cycle.

  // Entry storage
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] adel_q;
  logic [DEPTH-1:0] filled_q;

  // Pointers and counters
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] fill_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] unfilled_cnt;
  logic          fill_found;
  logic [AW-1:0] scan_idx;

  logic          alloc_en;
  logic          fill_en;
  logic          drop_en;
  logic          pop_en;
  logic          head_valid;
  logic [CW:0]   occupancy;
  logic [CW:0]   flush_sum;
  logic [CW:0]   flush_drop;

  // AdEL entries are born filled, so the first unfilled slot from the head is
  // always the cache entry owed the next response.
  always_comb begin
    fill_found   = 1'b0;
    fill_ptr     = rd_ptr;
    unfilled_cnt = '0;
    scan_idx     = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + AW'(i);
      if ((CW'(i) < count) && !filled_q[scan_idx]) begin
        unfilled_cnt = unfilled_cnt + CW'(1);
        if (!fill_found) begin
          fill_found = 1'b1;
          fill_ptr   = scan_idx;
        end
      end
    end
  end

  assign head_valid = (count != '0);
  assign occupancy  = {1'b0, count} + {1'b0, drop_cnt};
  assign Q_Full     = (occupancy >= DEPTH_W);

  assign alloc_en = Req_Valid & ~IF_Flush & ~Q_Full;
  assign fill_en  = Resp_Valid & ~IF_Flush & (drop_cnt == '0) & fill_found;
  assign drop_en  = Resp_Valid & ~IF_Flush & (drop_cnt != '0);
  assign pop_en   = IF_Valid & ID_Ready & ~IF_Flush;

  always_comb begin
    count_next = count;
    case ({alloc_en, pop_en})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Responses still owed at a redirect: queued cache entries, plus the fetch
  // issued in the flush cycle, less a response arriving in that same cycle.
  always_comb begin
    flush_sum = {1'b0, drop_cnt} + {1'b0, unfilled_cnt} +
                (CW + 1)'(Req_Valid & ~Req_AdEL);
    if (Resp_Valid && (flush_sum != '0)) begin
      flush_drop = flush_sum - (CW + 1)'(1);
    end else begin
      flush_drop = flush_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      filled_q <= '0;
    end else if (IF_Flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= flush_drop[CW-1:0];
      filled_q <= '0;
    end else begin
      if (alloc_en) begin
        wr_ptr           <= wr_ptr + AW'(1);
        filled_q[wr_ptr] <= Req_AdEL;
      end
      if (fill_en) begin
        filled_q[fill_ptr] <= 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (drop_en) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      count <= count_next;
    end
  end

  // Payload needs no reset: it is only visible through occupied slots.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      pc_q[wr_ptr]    <= Req_PC;
      instr_q[wr_ptr] <= '0;
      adel_q[wr_ptr]  <= Req_AdEL;
    end
    if (fill_en) begin
      instr_q[fill_ptr] <= Resp_Instr;
    end
  end

  assign IF_Valid = head_valid & filled_q[rd_ptr];
  assign IF_PC    = head_valid ? pc_q[rd_ptr]    : 32'h0;
  assign IF_Instr = head_valid ? instr_q[rd_ptr] : 32'h0;
  assign IF_AdEL  = head_valid & adel_q[rd_ptr];

endmodule

// File: tb/tb_if_instr_queue.sv
// Directed bench for if_instr_queue: reset, streaming, back-pressure, flush and AdEL ordering.
module tb_if_instr_queue;

  logic        clk;
  logic        rst;
  logic        IF_Flush;
  logic        Req_Valid;
  logic [31:0] Req_PC;
  logic        Req_AdEL;
  logic        Resp_Valid;
  logic [31:0] Resp_Instr;
  logic        ID_Ready;
  logic        Q_Full;
  logic        IF_Valid;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instr;
  logic        IF_AdEL;

  int checks;
  int fails;

  if_instr_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .IF_Flush   (IF_Flush),
    .Req_Valid  (Req_Valid),
    .Req_PC     (Req_PC),
    .Req_AdEL   (Req_AdEL),
    .Resp_Valid (Resp_Valid),
    .Resp_Instr (Resp_Instr),
    .ID_Ready   (ID_Ready),
    .Q_Full     (Q_Full),
    .IF_Valid   (IF_Valid),
    .IF_PC      (IF_PC),
    .IF_Instr   (IF_Instr),
    .IF_AdEL    (IF_AdEL)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    IF_Flush   = 1'b0;
    Req_Valid  = 1'b0;
    Req_PC     = 32'h0;
    Req_AdEL   = 1'b0;
    Resp_Valid = 1'b0;
    Resp_Instr = 32'h0;
    ID_Ready   = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Driver tasks
  task automatic drive_req(input logic [31:0] pc, input logic adel);
    Req_Valid = 1'b1;
    Req_PC    = pc;
    Req_AdEL  = adel;
  endtask

  task automatic drive_resp(input logic [31:0] instr);
    Resp_Valid = 1'b1;
    Resp_Instr = instr;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (IF_Valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", IF_Valid); end
    checks++; if (IF_PC !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", IF_PC); end
    checks++; if (IF_Instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", IF_Instr); end
    checks++; if (IF_AdEL !== 1'b0) begin fails++; $display("FAIL reset_adel: got %0b want 0", IF_AdEL); end
    checks++; if (Q_Full !== 1'b0) begin fails++; $display("FAIL reset_full: got %0b want 0", Q_Full); end
    drive_req(32'hBFC0_0000, 1'b0);
    tick();
    clear_inputs();
    drive_resp(32'h3C1A_8000);
    checks++; if (IF_Valid !== 1'b0) begin fails++; $display("FAIL reset_unfilled: got %0b want 0", IF_Valid); end
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b1) begin fails++; $display("FAIL reset_first_valid: got %0b want 1", IF_Valid); end
    checks++; if (IF_PC !== 32'hBFC0_0000) begin fails++; $display("FAIL reset_first_pc: got %h want bfc00000", IF_PC); end
    checks++; if (IF_Instr !== 32'h3C1A_8000) begin fails++; $display("FAIL reset_first_instr: got %h want 3c1a8000", IF_Instr); end
    ID_Ready = 1'b1;
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b0) begin fails++; $display("FAIL reset_pop_empty: got %0b want 0", IF_Valid); end
  endtask

  task automatic test_streaming;
    do_reset();
    ID_Ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      Req_Valid  = (k < 8);
      Req_PC     = 32'h8000_0000 + 32'(4 * k);
      Req_AdEL   = 1'b0;
      Resp_Valid = (k >= 1);
      Resp_Instr = 32'h2400_0000 | 32'(k - 1);
      tick();
      checks++; if (Q_Full !== 1'b0) begin fails++; $display("FAIL stream_full k=%0d: got %0b want 0", k, Q_Full); end
      if (k >= 1) begin
        checks++; if (IF_Valid !== 1'b1) begin fails++; $display("FAIL stream_valid k=%0d: got %0b want 1", k, IF_Valid); end
        checks++; if (IF_PC !== 32'h8000_0000 + 32'(4 * (k - 1))) begin fails++; $display("FAIL stream_pc k=%0d: got %h want %h", k, IF_PC, 32'h8000_0000 + 32'(4 * (k - 1))); end
        checks++; if (IF_Instr !== (32'h2400_0000 | 32'(k - 1))) begin fails++; $display("FAIL stream_instr k=%0d: got %h want %h", k, IF_Instr, 32'h2400_0000 | 32'(k - 1)); end
      end
    end
    clear_inputs();
    ID_Ready = 1'b1;
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b0) begin fails++; $display("FAIL stream_drained: got %0b want 0", IF_Valid); end
  endtask

  task automatic test_back_pressure;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_req(32'h8000_1000 + 32'(4 * k), 1'b0);
      Resp_Valid = (k >= 1);
      Resp_Instr = 32'h3400_0000 | 32'(k - 1);
      tick();
      checks++; if (Q_Full !== (k == 3)) begin fails++; $display("FAIL bp_full k=%0d: got %0b want %0b", k, Q_Full, k == 3); end
    end
    // Request while full must be ignored.
    clear_inputs();
    drive_resp(32'h3400_0003);
    drive_req(32'hDEAD_0000, 1'b0);
    tick();
    clear_inputs();
    checks++; if (Q_Full !== 1'b1) begin fails++; $display("FAIL bp_still_full: got %0b want 1", Q_Full); end
    checks++; if (IF_PC !== 32'h8000_1000) begin fails++; $display("FAIL bp_head_pc: got %h want 80001000", IF_PC); end
    ID_Ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (Q_Full !== 1'b0) begin fails++; $display("FAIL bp_release_full k=%0d: got %0b want 0", k, Q_Full); end
      if (k < 4) begin
        checks++; if (IF_PC !== 32'h8000_1000 + 32'(4 * k)) begin fails++; $display("FAIL bp_order_pc k=%0d: got %h want %h", k, IF_PC, 32'h8000_1000 + 32'(4 * k)); end
        checks++; if (IF_Instr !== (32'h3400_0000 | 32'(k))) begin fails++; $display("FAIL bp_order_instr k=%0d: got %h want %h", k, IF_Instr, 32'h3400_0000 | 32'(k)); end
      end else begin
        checks++; if (IF_Valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %0b want 0", IF_Valid); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_flush_in_flight;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_req(32'h8000_0010 + 32'(4 * k), 1'b0);
      tick();
    end
    drive_req(32'h8000_001C, 1'b0);
    IF_Flush = 1'b1;
    checks++; if (IF_Valid !== 1'b0 || IF_PC !== 32'h8000_0010) begin fails++; $display("FAIL flush_not_yet_empty: got pc %h want 80000010", IF_PC); end
    tick();
    clear_inputs();
    checks++; if (IF_PC !== 32'h0) begin fails++; $display("FAIL flush_empty: got pc %h want 0", IF_PC); end
    checks++; if (Q_Full !== 1'b1) begin fails++; $display("FAIL flush_full_drop4: got %0b want 1", Q_Full); end
    for (int k = 1; k <= 4; k++) begin
      clear_inputs();
      drive_resp(32'hBAD0_0000 | 32'(k));
      if (k == 2) drive_req(32'h8000_0100, 1'b0);
      tick();
      checks++; if (IF_Valid !== 1'b0) begin fails++; $display("FAIL flush_discard k=%0d: got %0b want 0", k, IF_Valid); end
      checks++; if (Q_Full !== 1'b0) begin fails++; $display("FAIL flush_full k=%0d: got %0b want 0", k, Q_Full); end
    end
    clear_inputs();
    checks++; if (IF_PC !== 32'h8000_0100) begin fails++; $display("FAIL flush_new_pc: got %h want 80000100", IF_PC); end
    drive_resp(32'h8C88_0000);
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b1) begin fails++; $display("FAIL flush_fifth_valid: got %0b want 1", IF_Valid); end
    checks++; if (IF_Instr !== 32'h8C88_0000) begin fails++; $display("FAIL flush_fifth_instr: got %h want 8c880000", IF_Instr); end
  endtask

  task automatic test_adel_order;
    do_reset();
    drive_req(32'h8000_0000, 1'b0);
    tick();
    drive_req(32'h8000_0006, 1'b1);
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b0) begin fails++; $display("FAIL adel_wait: got %0b want 0", IF_Valid); end
    drive_resp(32'h3C08_8000);
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b1 || IF_PC !== 32'h8000_0000) begin fails++; $display("FAIL adel_first_pc: got %h want 80000000", IF_PC); end
    checks++; if (IF_Instr !== 32'h3C08_8000 || IF_AdEL !== 1'b0) begin fails++; $display("FAIL adel_first_instr: got %h want 3c088000", IF_Instr); end
    ID_Ready = 1'b1;
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b1 || IF_PC !== 32'h8000_0006) begin fails++; $display("FAIL adel_second_pc: got %h want 80000006", IF_PC); end
    checks++; if (IF_AdEL !== 1'b1) begin fails++; $display("FAIL adel_flag: got %0b want 1", IF_AdEL); end
    checks++; if (IF_Instr !== 32'h0) begin fails++; $display("FAIL adel_instr_zero: got %h want 0", IF_Instr); end
    ID_Ready = 1'b1;
    drive_req(32'h8000_0103, 1'b1);
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b1 || IF_PC !== 32'h8000_0103) begin fails++; $display("FAIL adel_latency: got valid %0b pc %h want 1 80000103", IF_Valid, IF_PC); end
  endtask

  task automatic test_flush_resp;
    do_reset();
    drive_req(32'h8000_0200, 1'b0);
    tick();
    drive_req(32'h8000_0204, 1'b0);
    tick();
    clear_inputs();
    IF_Flush = 1'b1;
    drive_resp(32'hBAD0_0011);
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b0 || Q_Full !== 1'b0) begin fails++; $display("FAIL fr_after_flush: got valid %0b full %0b want 0 0", IF_Valid, Q_Full); end
    drive_req(32'h8000_0300, 1'b0);
    drive_resp(32'hBAD0_0012);
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b0) begin fails++; $display("FAIL fr_discard: got %0b want 0", IF_Valid); end
    checks++; if (IF_PC !== 32'h8000_0300) begin fails++; $display("FAIL fr_new_pc: got %h want 80000300", IF_PC); end
    drive_resp(32'h0085_1021);
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b1 || IF_Instr !== 32'h0085_1021) begin fails++; $display("FAIL fr_fill: got valid %0b instr %h want 1 00851021", IF_Valid, IF_Instr); end
  endtask

  task automatic test_stray;
    do_reset();
    drive_resp(32'h1111_1111);
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b0 || Q_Full !== 1'b0) begin fails++; $display("FAIL stray_ignored: got valid %0b full %0b want 0 0", IF_Valid, Q_Full); end
    IF_Flush = 1'b1;
    drive_resp(32'h2222_2222);
    tick();
    clear_inputs();
    drive_req(32'h8000_0400, 1'b0);
    tick();
    clear_inputs();
    drive_resp(32'h2408_0001);
    tick();
    clear_inputs();
    checks++; if (IF_Valid !== 1'b1 || IF_Instr !== 32'h2408_0001) begin fails++; $display("FAIL stray_flush_no_drop: got valid %0b instr %h want 1 24080001", IF_Valid, IF_Instr); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_in_flight();
    test_adel_order();
    test_flush_resp();
    test_stray();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/if_instr_queue.md
# if_instr_queue

In-order fetch tracking queue between the pre-IF stage (PC generation, I-cache request) and the ID stage. An entry is allocated with its PC when a fetch is issued, is filled when the I-cache returns the instruction, and is presented to ID in program order. On a pipeline redirect it flushes all entries and discards the I-cache responses still in flight for wrong-path fetches. `Q_Full` is the back-pressure signal that gates `PREIF_Wr`.

## Interface
Parameters:
- `DEPTH`, 4: number of entries, a power of two ≥ 2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `IF_Flush` in 1: redirect (branch, jump, exception or eret). Kills all queued and in-flight fetches.
- `Req_Valid` in 1: a fetch is issued this cycle.
- `Req_PC` in 32: PC of the issued fetch.
- `Req_AdEL` in 1: `Req_PC[1:0]!=0`. No cache request is made for this fetch.
- `Resp_Valid` in 1: the I-cache returns one instruction, in request order.
- `Resp_Instr` in 32: the returned instruction word.
- `ID_Ready` in 1: ID consumes the head entry this cycle.
- `Q_Full` out 1: PREIF must not issue a fetch.
- `IF_Valid` out 1: the head entry is filled.
- `IF_PC` out 32: head PC.
- `IF_Instr` out 32: head instruction. It is 0 for an AdEL entry.
- `IF_AdEL` out 1: head entry carries an instruction address error.

## Operation
- Storage is a circular buffer of `DEPTH` entries. Each entry holds {PC, instr, AdEL, filled}.
- Pointers and counters:
  - `wr_ptr` is the allocation pointer.
  - `fill_ptr` points at the oldest unfilled cache entry.
  - `rd_ptr` is the head.
  - `count` is the number of occupied entries.
  - `drop_cnt` is the number of wrong-path responses still owed by the I-cache. It is `clog2(DEPTH)+1` bits wide.
- Pointers are `clog2(DEPTH)` bits wide and wrap modulo `DEPTH`.
- Allocate, when `Req_Valid & ~IF_Flush`:
  - Write {`Req_PC`, 0, `Req_AdEL`, filled=`Req_AdEL`} at `wr_ptr`, then advance `wr_ptr`.
  - `Req_Valid` while `Q_Full` is a protocol violation. The request is ignored and no state changes.
- Fill, when `Resp_Valid & drop_cnt==0 & ~IF_Flush`:
  - The response belongs to the oldest unfilled non-AdEL entry.
  - `fill_ptr` skips AdEL entries. The next unfilled cache entry is found by scanning forward from `rd_ptr`.
  - Write `Resp_Instr` into that entry and set filled=1.
- Drop, when `Resp_Valid & drop_cnt!=0 & ~IF_Flush`: decrement `drop_cnt` and discard the data.
- Stray response (`Resp_Valid` with no unfilled cache entry and `drop_cnt==0`): ignored.
- Pop, when `IF_Valid & ID_Ready & ~IF_Flush`: advance `rd_ptr`.
- `count`:
  - Counts allocations minus pops in the same cycle.
  - Allocate and pop in the same cycle leaves `count` unchanged.
  - The head may be popped in the cycle its neighbour is allocated.
- `Q_Full = (count + drop_cnt) >= DEPTH`. This bounds total I-cache outstanding requests to `DEPTH`.
- `IF_Flush` has priority over every other event in its cycle:
  - All entries are invalidated. All pointers and `count` go to 0.
  - `drop_cnt_next = drop_cnt + P + (Req_Valid & ~Req_AdEL) - Resp_Valid`, where P is the number of unfilled non-AdEL entries.
  - A `Req_Valid` in the flush cycle is not allocated, but its cache request is counted in `drop_cnt`.
  - A `Resp_Valid` in the flush cycle is discarded and counted against `drop_cnt`.
  - A pop in the flush cycle is void. ID flushes its own register in the same cycle.
- `rst` clears all pointers, `count`, `drop_cnt` and all filled bits.

## Timing
- Reset values: `IF_Valid`=0, `IF_PC`=0, `IF_Instr`=0, `IF_AdEL`=0, `Q_Full`=0.
- All outputs are combinational from registered state only. There is no input-to-output path.
- Cache entry latency: allocate in cycle N, `Resp_Valid` in cycle M≥N+1, and `IF_Valid` rises in M+1 if the entry is the head.
- AdEL entry latency: allocate in N, `IF_Valid` in N+1 if it is the head.
- Throughput: one allocate, one fill and one pop per cycle, sustained.
- `Q_Full` updates the cycle after the allocate or drop that changes it.
- The queue does not empty in the flush cycle; it reads as empty from the cycle after `IF_Flush`.
- Fetches issued after a flush are accepted the next cycle if `Q_Full`=0. Their responses are accepted only after `drop_cnt` reaches 0.

## Test plan
- **Reset:** hold `rst` for 2 cycles, then release. All outputs read 0. `Req_Valid` at 0xBFC00000, `Resp_Valid` next cycle with 0x3C1A8000 → `IF_Valid`=1, `IF_PC`=0xBFC00000, `IF_Instr`=0x3C1A8000 two cycles after the request.
- **Streaming:** `ID_Ready`=1 constantly. PCs 0x80000000,+4,+8… each answered 1 cycle later. One instruction is output per cycle and `Q_Full` never rises.
- **Back-pressure:** `ID_Ready`=0 with 4 requests answered. `Q_Full`=1 from the cycle after the 4th allocate. Raise `ID_Ready`: the 4 entries pop in order and `Q_Full` drops one cycle after the first pop.
- **Flush with 3 in flight:**
  - Issue 3 fetches with no responses, then assert `IF_Flush` together with a 4th `Req_Valid`. `drop_cnt`=4.
  - Issue a new fetch at 0x80000100. Its response is the 5th `Resp_Valid`.
  - Responses 1–4 are discarded. Only 0x80000100 reaches ID.
- **AdEL ordering:** request 0x80000000 (cache), then 0x80000006 (AdEL). The AdEL entry waits behind the first. Output order is 0x80000000 then 0x80000006 with `IF_AdEL`=1 and `IF_Instr`=0.
- **Flush coinciding with a response:** assert `IF_Flush` in the same cycle as `Resp_Valid` with 2 pending. `drop_cnt`=1, and the next response is discarded.
